// File: rtl/vs0_wb_arbiter.sv
// vs0_wb_arbiter: two-requester Wishbone (pipelined) arbiter in front of one shared slave.
// Define VS0_WB_ARB_TIMEOUT_EN to add the hung-slave watchdog and the ABORT state.
//
// state  | meaning
// IDLE   | no owner, slave bus idle, both requesters stalled
// GRANT0 | m0 owns the slave bus, signals passed straight through
// GRANT1 | m1 owns the slave bus, signals passed straight through
// ABORT  | one-cycle error to the owner after a watchdog expiry, bus dropped
module vs0_wb_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic [27:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic        m0_stall_o,
   input  logic [27:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        m1_stall_o,
   output logic [27:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   input  logic        s_stall_i,
   output logic [1:0]  grant_o
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ABORT} state_t;

   state_t     state, state_nxt;
   logic       last_grant, last_grant_nxt;   // 1 = m1 was granted last
   logic [4:0] outstanding, outstanding_nxt;
   logic [1:0] grant_nxt;
   logic       timeout_hit;
   logic       accept, done, hold;

   if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("vs0_wb_arbiter: TIMEOUT_CYCLES must be within 16..65535");
   end

`ifdef VS0_WB_ARB_TIMEOUT_EN
   logic [15:0] wd;
   logic        wd_waiting;

   assign wd_waiting  = (state == GRANT0 || state == GRANT1) && (outstanding != 5'd0)
                        && !(s_ack_i || s_err_i);
   assign timeout_hit = wd_waiting && (wd == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)          wd <= '0;
      else if (wd_waiting) wd <= wd + 16'd1;
      else                 wd <= '0;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (m0_cyc_i && (!m1_cyc_i || last_grant)) begin
               state_nxt      = GRANT0;
               last_grant_nxt = 1'b0;
            end else if (m1_cyc_i) begin
               state_nxt      = GRANT1;
               last_grant_nxt = 1'b1;
            end
         end
         GRANT0: begin
            if (!m0_cyc_i)        state_nxt = IDLE;
            else if (timeout_hit) state_nxt = ABORT;
         end
         GRANT1: begin
            if (!m1_cyc_i)        state_nxt = IDLE;
            else if (timeout_hit) state_nxt = ABORT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_adr_o    = '0;
      s_dat_o    = '0;
      s_sel_o    = '0;
      s_we_o     = 1'b0;
      s_cyc_o    = 1'b0;
      s_stb_o    = 1'b0;
      m0_dat_o   = '0;
      m0_ack_o   = 1'b0;
      m0_err_o   = 1'b0;
      m0_stall_o = 1'b1;
      m1_dat_o   = '0;
      m1_ack_o   = 1'b0;
      m1_err_o   = 1'b0;
      m1_stall_o = 1'b1;
      case (state)
         GRANT0: begin
            s_adr_o    = m0_adr_i;
            s_dat_o    = m0_dat_i;
            s_sel_o    = m0_sel_i;
            s_we_o     = m0_we_i;
            s_cyc_o    = m0_cyc_i;
            s_stb_o    = m0_stb_i;
            m0_dat_o   = s_dat_i;
            m0_ack_o   = s_ack_i;
            m0_err_o   = s_err_i;
            m0_stall_o = s_stall_i;
         end
         GRANT1: begin
            s_adr_o    = m1_adr_i;
            s_dat_o    = m1_dat_i;
            s_sel_o    = m1_sel_i;
            s_we_o     = m1_we_i;
            s_cyc_o    = m1_cyc_i;
            s_stb_o    = m1_stb_i;
            m1_dat_o   = s_dat_i;
            m1_ack_o   = s_ack_i;
            m1_err_o   = s_err_i;
            m1_stall_o = s_stall_i;
         end
         ABORT: begin
            m0_err_o = !last_grant;
            m1_err_o = last_grant;
         end
         default: ;
      endcase
   end

   // Anything other than staying with the same owner clears the count, so
   // late responses from an abandoned cycle are never credited to anyone.
   assign accept = s_stb_o && !s_stall_i;
   assign done   = (s_ack_i || s_err_i) && (outstanding != 5'd0);
   assign hold   = (state == GRANT0 && state_nxt == GRANT0) ||
                   (state == GRANT1 && state_nxt == GRANT1);

   always_comb begin
      outstanding_nxt = '0;
      if (hold) begin
         outstanding_nxt = outstanding;
         if (accept && !done && outstanding != 5'd31) outstanding_nxt = outstanding + 5'd1;
         else if (done && !accept)                    outstanding_nxt = outstanding - 5'd1;
      end
   end

   always_comb begin
      grant_nxt = 2'b00;
      case (state_nxt)
         GRANT0:  grant_nxt = 2'b01;
         GRANT1:  grant_nxt = 2'b10;
         ABORT:   grant_nxt = last_grant_nxt ? 2'b10 : 2'b01;
         default: grant_nxt = 2'b00;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         outstanding <= '0;
         grant_o     <= 2'b00;
      end else begin
         state       <= state_nxt;
         last_grant  <= last_grant_nxt;
         outstanding <= outstanding_nxt;
         grant_o     <= grant_nxt;
      end
   end

endmodule

// File: tb/tb_vs0_wb_arbiter.sv
// Bench for vs0_wb_arbiter: ownership/outstanding model checked every cycle, plus directed scenarios.
module tb_vs0_wb_arbiter;
   logic        sys_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic [27:0] m0_adr_i = '0, m1_adr_i = '0;
   logic [31:0] m0_dat_i = '0, m1_dat_i = '0, s_dat_i = '0;
   logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
   logic        m0_we_i = 0, m0_cyc_i = 0, m0_stb_i = 0;
   logic        m1_we_i = 0, m1_cyc_i = 0, m1_stb_i = 0;
   logic        s_ack_i = 0, s_err_i = 0, s_stall_i = 0;
   logic [31:0] m0_dat_o, m1_dat_o, s_dat_o;
   logic        m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o;
   logic [27:0] s_adr_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o;
   logic [1:0]  grant_o;

   always #5 sys_clk = ~sys_clk;

   vs0_wb_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
      .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
      .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_err_i(s_err_i), .s_stall_i(s_stall_i), .grant_o(grant_o)
   );

   int vectors = 0;
   int fails   = 0;
   bit model_en = 1'b1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: who owns the bus (0 none, 1 m0, 2 m1), fairness memory, outstanding count.
   int owner, m_cnt, m_nxt;
   bit last_m1, m_stb, m_acc, m_dn;

   always @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         owner = 0; last_m1 = 1'b1; m_cnt = 0;
      end else begin
         m_nxt = owner;
         if (owner == 0) begin
            if (m0_cyc_i && (!m1_cyc_i || last_m1)) begin m_nxt = 1; last_m1 = 1'b0; end
            else if (m1_cyc_i)                      begin m_nxt = 2; last_m1 = 1'b1; end
         end else if (owner == 1 && !m0_cyc_i) m_nxt = 0;
         else if (owner == 2 && !m1_cyc_i)     m_nxt = 0;
         m_stb = (owner == 1) ? m0_stb_i : (owner == 2) ? m1_stb_i : 1'b0;
         m_acc = m_stb && !s_stall_i;
         m_dn  = (s_ack_i || s_err_i) && m_cnt > 0;
         if (m_acc && !m_dn)      m_cnt = (m_cnt == 31) ? 31 : m_cnt + 1;
         else if (m_dn && !m_acc) m_cnt = m_cnt - 1;
         if (m_nxt != owner || owner == 0) m_cnt = 0;
         owner = m_nxt;
      end
   end

   logic [1:0]  e_grant;
   logic        e_cyc, e_stb, e0_stall, e0_ack, e0_err, e1_stall, e1_ack, e1_err;
   logic [31:0] e0_dat, e1_dat;

   always @(negedge sys_clk) begin
      if (model_en) begin
         e_grant  = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
         e_cyc    = (owner == 1) ? m0_cyc_i : (owner == 2) ? m1_cyc_i : 1'b0;
         e_stb    = (owner == 1) ? m0_stb_i : (owner == 2) ? m1_stb_i : 1'b0;
         e0_stall = (owner == 1) ? s_stall_i : 1'b1;
         e1_stall = (owner == 2) ? s_stall_i : 1'b1;
         e0_ack   = (owner == 1) && s_ack_i;
         e1_ack   = (owner == 2) && s_ack_i;
         e0_err   = (owner == 1) && s_err_i;
         e1_err   = (owner == 2) && s_err_i;
         e0_dat   = (owner == 1) ? s_dat_i : 32'h0;
         e1_dat   = (owner == 2) ? s_dat_i : 32'h0;
         check("ctrl", {grant_o, s_cyc_o, s_stb_o, m0_stall_o, m0_ack_o, m0_err_o, m1_stall_o, m1_ack_o, m1_err_o},
                       {e_grant, e_cyc, e_stb, e0_stall, e0_ack, e0_err, e1_stall, e1_ack, e1_err});
         check("m0_dat", m0_dat_o, e0_dat);
         check("m1_dat", m1_dat_o, e1_dat);
         check("outstanding", dut.outstanding, m_cnt);
         if (owner == 1) check("s_path", {s_adr_o, s_dat_o, s_sel_o, s_we_o}, {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i});
         if (owner == 2) check("s_path", {s_adr_o, s_dat_o, s_sel_o, s_we_o}, {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i});
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   int beat, stalls, acks, acc_seen, m0_free, nbeats;
   bit pend, seen;

   initial begin
      // Reset values
      repeat (3) @(negedge sys_clk);
      check("rst_grant", grant_o, 2'b00);
      check("rst_bus", {m0_stall_o, m1_stall_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o}, 6'b110000);
      tick(); rst_n = 1'b1;
      tick();

      // Single read from m0, acked two cycles after the strobe
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 28'h0000010; m0_sel_i = 4'hF; m0_we_i = 0;
      @(negedge sys_clk); check("t1_latency", {grant_o, s_stb_o}, 3'b000);
      tick();
      @(negedge sys_clk); check("t1_stb", {grant_o, s_stb_o, s_adr_o}, {2'b01, 1'b1, 28'h0000010});
      check("t1_m1_stall", m1_stall_o, 1'b1);
      tick(); m0_stb_i = 0;
      tick(); s_ack_i = 1; s_dat_i = 32'h0000510B;
      @(negedge sys_clk); check("t1_ack", {m0_ack_o, m0_dat_o}, {1'b1, 32'h0000510B});
      check("t1_m1_quiet", {m1_ack_o, m1_dat_o, m1_stall_o}, {1'b0, 32'h0, 1'b1});
      tick(); s_ack_i = 0; s_dat_i = 0; m0_cyc_i = 0;
      tick(); @(negedge sys_clk); check("t1_release", grant_o, 2'b00);

      // Simultaneous requests after reset, stray ack forwarded, handover gap
      rst_n = 0; tick(); rst_n = 1; tick();
      m0_cyc_i = 1; m1_cyc_i = 1;
      tick(); @(negedge sys_clk); check("t2_first", grant_o, 2'b01);
      tick(); s_ack_i = 1;
      @(negedge sys_clk); check("t2_stray_ack", {m0_ack_o, m1_ack_o}, 2'b10);
      tick(); s_ack_i = 0; m0_cyc_i = 0;
      tick(); @(negedge sys_clk); check("t2_gap", grant_o, 2'b00);
      tick(); @(negedge sys_clk); check("t2_second", grant_o, 2'b10);
      tick(); m1_cyc_i = 0;
      tick();

      // m1 4-beat pipelined burst, beat 1 stalled for 3 cycles, m0 waiting
      m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 28'h100; m1_sel_i = 4'hF; m1_we_i = 1; m1_dat_i = 32'hA0;
      tick();
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 28'h200;
      beat = 0; stalls = 0; acks = 0; acc_seen = 0; m0_free = 0; pend = 0;
      for (int c = 0; c < 30 && acks < 4; c++) begin
         m1_stb_i  = (beat < 4);
         m1_adr_i  = 28'h100 + 28'(beat);
         m1_dat_i  = 32'hA0 + 32'(beat);
         s_stall_i = (beat == 1 && stalls < 3);
         s_ack_i   = pend;
         @(negedge sys_clk);
         if (m1_ack_o) acks++;
         if (s_stb_o && !s_stall_i) acc_seen++;
         if (!m0_stall_o) m0_free++;
         pend = m1_stb_i && !s_stall_i;
         if (pend) beat++;
         if (s_stall_i) stalls++;
         tick();
      end
      check("t3_accepted", acc_seen, 4);
      check("t3_acks", acks, 4);
      check("t3_m0_stalled", m0_free, 0);
      s_ack_i = 0; s_stall_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      @(negedge sys_clk); check("t3_drained", dut.outstanding, 5'd0);
      tick();
      tick(); @(negedge sys_clk); check("t3_handover", grant_o, 2'b01);

      // m0 abandons two outstanding strobes; late ack must vanish
      tick(); m1_cyc_i = 1;
      tick(); m0_cyc_i = 0; m0_stb_i = 0;
      @(negedge sys_clk); check("t4_outstanding", dut.outstanding, 5'd2);
      tick(); s_ack_i = 1;
      @(negedge sys_clk); check("t4_discard", {m0_ack_o, m1_ack_o, grant_o}, 4'b0000);
      tick(); s_ack_i = 0; m1_stb_i = 1;
      @(negedge sys_clk); check("t4_grant", {grant_o, m1_ack_o}, 3'b100);

      // Reset during an m1 burst
      tick(); s_ack_i = 1;
      #2 rst_n = 0;
      #1 check("t5_async", {grant_o, s_cyc_o, s_stb_o, m1_stall_o, m1_ack_o, m0_stall_o}, 6'b000101);
      tick(); tick();
      rst_n = 1; m1_cyc_i = 0; m1_stb_i = 0;
      @(negedge sys_clk); check("t5_no_ack", {m0_ack_o, m1_ack_o}, 2'b00);
      tick(); s_ack_i = 0; m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 28'h300;
      tick(); @(negedge sys_clk); check("t5_regrant", grant_o, 2'b01);

      // Hung slave: strobes never acknowledged
`ifdef VS0_WB_ARB_TIMEOUT_EN
      nbeats = 1;
`else
      nbeats = 33;
`endif
      repeat (nbeats) tick();
      m0_stb_i = 0;
      @(negedge sys_clk); check("t6_count", dut.outstanding, (nbeats > 31) ? 31 : nbeats);
`ifdef VS0_WB_ARB_TIMEOUT_EN
      model_en = 0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         tick();
         @(negedge sys_clk);
         if (m0_err_o) begin
            seen = 1;
            check("t6_abort", {s_cyc_o, m1_err_o, grant_o}, 4'b0001);
         end
      end
      check("t6_err_seen", seen, 1'b1);
      tick(); @(negedge sys_clk); check("t6_after_abort", {m0_err_o, grant_o}, 3'b000);
      m0_cyc_i = 0;
      tick(); tick();
`else
      repeat (100) tick();
      @(negedge sys_clk); check("t6_hold", {grant_o, m0_err_o}, 3'b010);
      tick(); m0_cyc_i = 0;
      tick(); tick();
      @(negedge sys_clk); check("t6_release", {grant_o, dut.outstanding}, 7'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end of test, expected finish");
      $fatal(1, "bench time limit");
   end
endmodule
